// File: rtl/step_divider.sv
// Sequential restoring radix-2 divider: quotinent = (divident << FRAC_BITS) / divisor.
// Optional STEP_DIVIDER_SHORTCUT_EN finishes zero-operand divisions in two edges.
module step_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           divident,
  input  logic [WIDTH-1:0]           divisor,
  input  logic                       start_divide,
  output logic [WIDTH+FRAC_BITS-1:0] quotinent,
  output logic                       divide_done,
  output logic                       busy,
  output logic                       div_by_zero
);

  localparam int QW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   num_q, num_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]  rem_q, rem_d;
  logic [QW-1:0]   q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   quot_q, quot_d;
  logic            dbz_q, dbz_d;
`ifdef STEP_DIVIDER_SHORTCUT_EN
  logic            short_q, short_d;
`endif

  logic [WIDTH:0]  trial;
  logic [WIDTH:0]  diff;
  logic            fits;

  // The 33-bit trial remainder keeps divisors >= 2^31 exact.
  always_comb begin
    trial = {rem_q[WIDTH-1:0], num_q[QW-1]};
    diff  = trial - {1'b0, dsr_q};
    fits  = (trial >= {1'b0, dsr_q});
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
`ifdef STEP_DIVIDER_SHORTCUT_EN
    short_d = short_q;
`endif

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
`ifdef STEP_DIVIDER_SHORTCUT_EN
        if (short_q) begin
          if (cnt_q == CW'(1)) begin
            quot_d = (dsr_q == '0) ? '1 : '0;
            dbz_d  = (dsr_q == '0);
          end
        end else
`endif
        begin
          num_d = num_q << 1;
          rem_d = fits ? diff : trial;
          q_d   = {q_q[QW-2:0], fits};
          if (cnt_q == '0) begin
            quot_d = {q_q[QW-2:0], fits};
            dbz_d  = (dsr_q == '0);
          end
        end
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start overrides whatever the current operation was doing.
    if (start_divide) begin
      state_d = S_RUN;
      num_d   = {divident, {FRAC_BITS{1'b0}}};
      dsr_d   = divisor;
      rem_d   = '0;
      q_d     = '0;
      cnt_d   = CW'(QW - 1);
`ifdef STEP_DIVIDER_SHORTCUT_EN
      short_d = (divisor == '0) || (divident == '0);
      if (short_d) cnt_d = CW'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef STEP_DIVIDER_SHORTCUT_EN
      short_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
`ifdef STEP_DIVIDER_SHORTCUT_EN
      short_q <= short_d;
`endif
    end
  end

  assign quotinent   = quot_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == S_RUN);
  assign divide_done = (state_q == S_DONE);

endmodule
